// File: rtl/alu_mon_pkg.sv
// Shared opcode encodings, FSM state and capture record for the ALU trojan monitor.
package alu_mon_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic {
        ST_MONITOR = 1'b0,
        ST_TRIPPED = 1'b1
    } mon_state_e;

    // One observed ALU transaction plus its golden result; also the stage-1 payload.
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [1:0]       op;
        logic [ALU_W-1:0] res;
        logic [ALU_W-1:0] exp_res;
        logic             cout;
        logic             exp_cout;
    } cap_rec_t;

endpackage

// File: rtl/alu_trojan_monitor_if.sv
// Sample bus from the ALU boundary into the monitor.
interface alu_trojan_monitor_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             smp_valid;
    logic [WIDTH-1:0] smp_a;
    logic [WIDTH-1:0] smp_b;
    logic [1:0]       smp_op;
    logic [WIDTH-1:0] smp_res;
    logic             smp_cout;

    modport master (output smp_valid, smp_a, smp_b, smp_op, smp_res, smp_cout);
    modport slave  (input  smp_valid, smp_a, smp_b, smp_op, smp_res, smp_cout);
endinterface

// File: rtl/alu_golden_model.sv
// Combinational reference ALU: the result the monitored ALU should have produced.
module alu_golden_model
    import alu_mon_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] exp_res,
    output logic             exp_cout
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Extra top bit carries the ADD carry-out or the SUB borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Opcode select of the golden result and carry.
    always_comb begin
        exp_res  = '0;
        exp_cout = 1'b0;
        case (op)
            OP_ADD: begin
                exp_res  = sum[WIDTH-1:0];
                exp_cout = sum[WIDTH];
            end
            OP_SUB: begin
                exp_res  = diff[WIDTH-1:0];
                exp_cout = diff[WIDTH];
            end
            OP_AND:  exp_res = a & b;
            OP_OR:   exp_res = a | b;
            default: exp_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_trojan_monitor.sv
// Two-stage checker: recomputes ALU results, counts mismatches, captures the first, trips an alarm.
module alu_trojan_monitor
    import alu_mon_pkg::*;
#(
    parameter int unsigned WIDTH       = ALU_W,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TRIP_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             smp_valid,
    input  logic [WIDTH-1:0] smp_a,
    input  logic [WIDTH-1:0] smp_b,
    input  logic [1:0]       smp_op,
    input  logic [WIDTH-1:0] smp_res,
    input  logic             smp_cout,
    output logic             chk_valid,
    output logic             chk_err,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             alarm,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic [1:0]       cap_op,
    output logic [WIDTH-1:0] cap_res,
    output logic [WIDTH-1:0] cap_exp_res,
    output logic             cap_cout,
    output logic             cap_exp_cout
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] TRIP_VAL = CNT_W'(TRIP_THRESH);

    alu_trojan_monitor_if #(.WIDTH(WIDTH)) smp_bus ();

    assign smp_bus.smp_valid = smp_valid;
    assign smp_bus.smp_a     = smp_a;
    assign smp_bus.smp_b     = smp_b;
    assign smp_bus.smp_op    = smp_op;
    assign smp_bus.smp_res   = smp_res;
    assign smp_bus.smp_cout  = smp_cout;

    logic [WIDTH-1:0] gold_res;
    logic             gold_cout;

    alu_golden_model #(.WIDTH(WIDTH)) u_golden (
        .a        (smp_bus.smp_a),
        .b        (smp_bus.smp_b),
        .op       (smp_bus.smp_op),
        .exp_res  (gold_res),
        .exp_cout (gold_cout)
    );

    logic             s1_valid_q,  s1_valid_d;
    cap_rec_t         s1_rec_q,    s1_rec_d;
    logic             chk_valid_q, chk_valid_d;
    logic             chk_err_q,   chk_err_d;
    logic [CNT_W-1:0] checked_q,   checked_d;
    logic [CNT_W-1:0] err_q,       err_d;
    mon_state_e       state_q,     state_d;
    logic             cap_valid_q, cap_valid_d;
    cap_rec_t         cap_q,       cap_d;
    logic             mismatch;

    assign mismatch = s1_valid_q && ((s1_rec_q.res  != s1_rec_q.exp_res) ||
                                     (s1_rec_q.cout != s1_rec_q.exp_cout));

    // Next-state for both pipeline stages, counters, capture and trip FSM; clr overrides all.
    always_comb begin
        s1_valid_d  = 1'b0;
        s1_rec_d    = s1_rec_q;
        chk_valid_d = 1'b0;
        chk_err_d   = 1'b0;
        checked_d   = checked_q;
        err_d       = err_q;
        state_d     = state_q;
        cap_valid_d = cap_valid_q;
        cap_d       = cap_q;

        if (clr) begin
            checked_d   = '0;
            err_d       = '0;
            state_d     = ST_MONITOR;
            cap_valid_d = 1'b0;
            cap_d       = '0;
        end else begin
            s1_valid_d = smp_bus.smp_valid;
            if (smp_bus.smp_valid) begin
                s1_rec_d.a        = ALU_W'(smp_bus.smp_a);
                s1_rec_d.b        = ALU_W'(smp_bus.smp_b);
                s1_rec_d.op       = smp_bus.smp_op;
                s1_rec_d.res      = ALU_W'(smp_bus.smp_res);
                s1_rec_d.exp_res  = ALU_W'(gold_res);
                s1_rec_d.cout     = smp_bus.smp_cout;
                s1_rec_d.exp_cout = gold_cout;
            end

            chk_valid_d = s1_valid_q;
            chk_err_d   = mismatch;

            if (s1_valid_q && (checked_q != CNT_MAX)) begin
                checked_d = checked_q + CNT_W'(1);
            end

            if (mismatch) begin
                if (err_q != CNT_MAX) begin
                    err_d = err_q + CNT_W'(1);
                end
                if (!cap_valid_q) begin
                    cap_valid_d = 1'b1;
                    cap_d       = s1_rec_q;
                end
                if ((state_q == ST_MONITOR) && (err_d >= TRIP_VAL)) begin
                    state_d = ST_TRIPPED;
                end
            end
        end
    end

    // State register with asynchronous clear of all in-flight and sticky state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_rec_q    <= '0;
            chk_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            checked_q   <= '0;
            err_q       <= '0;
            state_q     <= ST_MONITOR;
            cap_valid_q <= 1'b0;
            cap_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_rec_q    <= s1_rec_d;
            chk_valid_q <= chk_valid_d;
            chk_err_q   <= chk_err_d;
            checked_q   <= checked_d;
            err_q       <= err_d;
            state_q     <= state_d;
            cap_valid_q <= cap_valid_d;
            cap_q       <= cap_d;
        end
    end

    assign chk_valid    = chk_valid_q;
    assign chk_err      = chk_err_q;
    assign checked_cnt  = checked_q;
    assign err_cnt      = err_q;
    assign alarm        = (state_q == ST_TRIPPED);
    assign cap_valid    = cap_valid_q;
    assign cap_a        = WIDTH'(cap_q.a);
    assign cap_b        = WIDTH'(cap_q.b);
    assign cap_op       = cap_q.op;
    assign cap_res      = WIDTH'(cap_q.res);
    assign cap_exp_res  = WIDTH'(cap_q.exp_res);
    assign cap_cout     = cap_q.cout;
    assign cap_exp_cout = cap_q.exp_cout;

endmodule

// File: tb/tb_alu_trojan_monitor.sv
// Bench for alu_trojan_monitor: three instances (thresh 1 / thresh 3 / 4-bit counters) on one sample bus.
module tb_alu_trojan_monitor;
    import alu_mon_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    alu_trojan_monitor_if #(.WIDTH(4)) sif ();

    logic       cv[3], ce[3], al[3], capv[3], cc[3], cec[3];
    logic [7:0] ccnt[3], ecnt[3];
    logic [3:0] ca[3], cb[3], cr[3], cer[3];
    logic [1:0] cop[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned CW = (g == 2) ? 4 : 8;
        localparam int unsigned TH = (g == 1) ? 3 : 1;
        logic [CW-1:0] ck_cnt, er_cnt;

        alu_trojan_monitor #(.WIDTH(4), .CNT_W(CW), .TRIP_THRESH(TH)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .clr          (clr),
            .smp_valid    (sif.smp_valid),
            .smp_a        (sif.smp_a),
            .smp_b        (sif.smp_b),
            .smp_op       (sif.smp_op),
            .smp_res      (sif.smp_res),
            .smp_cout     (sif.smp_cout),
            .chk_valid    (cv[g]),
            .chk_err      (ce[g]),
            .checked_cnt  (ck_cnt),
            .err_cnt      (er_cnt),
            .alarm        (al[g]),
            .cap_valid    (capv[g]),
            .cap_a        (ca[g]),
            .cap_b        (cb[g]),
            .cap_op       (cop[g]),
            .cap_res      (cr[g]),
            .cap_exp_res  (cer[g]),
            .cap_cout     (cc[g]),
            .cap_exp_cout (cec[g])
        );

        assign ccnt[g] = 8'(ck_cnt);
        assign ecnt[g] = 8'(er_cnt);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int k, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int a; int b; int op; int res; int cout; int tab; int due;
    } item_t;

    item_t pipe_q[$];
    int    cyc = 0;
    int    thr[3]  = '{1, 3, 1};
    int    cmax[3] = '{255, 255, 15};
    int    m_chk[3], m_err[3];
    bit    m_alarm[3], m_capv[3];
    int    m_ca[3], m_cb[3], m_cop[3], m_cr[3], m_cc[3], m_cer[3], m_cec[3];
    bit    m_cv, m_ce;

    function automatic void golden(input int a, input int b, input int op, output int r, output int c);
        int s;
        case (op)
            0: begin s = a + b; r = s % 16; c = s / 16; end
            1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2: begin r = a & b; c = 0; end
            default: begin r = a | b; c = 0; end
        endcase
    endfunction

    task automatic model_clear();
        pipe_q.delete();
        m_cv = 0;
        m_ce = 0;
        for (int k = 0; k < 3; k++) begin
            m_chk[k] = 0; m_err[k] = 0; m_alarm[k] = 0; m_capv[k] = 0;
            m_ca[k] = 0; m_cb[k] = 0; m_cop[k] = 0; m_cr[k] = 0;
            m_cc[k] = 0; m_cer[k] = 0; m_cec[k] = 0;
        end
    endtask

    task automatic model_check(input item_t it);
        int er, ec;
        bit mism;
        golden(it.a, it.b, it.op, er, ec);
        mism = (it.res != er) || (it.cout != ec);
        m_cv = 1;
        m_ce = mism;
        for (int k = 0; k < 3; k++) begin
            if (m_chk[k] < cmax[k]) m_chk[k]++;
            if (mism) begin
                if (m_err[k] < cmax[k]) m_err[k]++;
                if (!m_capv[k]) begin
                    m_capv[k] = 1;
                    m_ca[k] = it.a; m_cb[k] = it.b; m_cop[k] = it.op;
                    m_cr[k] = it.res; m_cc[k] = it.cout;
                    m_cer[k] = er; m_cec[k] = ec;
                end
                if (m_err[k] >= thr[k]) m_alarm[k] = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check("chk_valid", k, cv[k], m_cv);
            check("chk_err", k, ce[k], m_ce);
            check("checked_cnt", k, ccnt[k], m_chk[k]);
            check("err_cnt", k, ecnt[k], m_err[k]);
            check("alarm", k, al[k], m_alarm[k]);
            check("cap_valid", k, capv[k], m_capv[k]);
            check("cap_a", k, ca[k], m_ca[k]);
            check("cap_b", k, cb[k], m_cb[k]);
            check("cap_op", k, cop[k], m_cop[k]);
            check("cap_res", k, cr[k], m_cr[k]);
            check("cap_cout", k, cc[k], m_cc[k]);
            check("cap_exp_res", k, cer[k], m_cer[k]);
            check("cap_exp_cout", k, cec[k], m_cec[k]);
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
    task automatic step(input bit v, input int a, input int b, input int op,
                        input int res, input int cout, input bit c, input int tab);
        item_t it;
        bit    popped;
        @(negedge clk);
        sif.smp_valid = v;
        sif.smp_a     = 4'(a);
        sif.smp_b     = 4'(b);
        sif.smp_op    = 2'(op);
        sif.smp_res   = 4'(res);
        sif.smp_cout  = 1'(cout);
        clr           = c;
        @(posedge clk);
        cyc++;
        popped = 0;
        m_cv = 0;
        m_ce = 0;
        if (c) begin
            model_clear();
        end else begin
            if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
                it = pipe_q.pop_front();
                model_check(it);
                popped = 1;
            end
            if (v) pipe_q.push_back('{a, b, op, res, cout, tab, cyc + 1});
        end
        #1;
        compare_all();
        if (popped && it.tab >= 0) check("table_chk_err", 0, ce[0], it.tab);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear with no clock edge.
    task automatic async_reset();
        @(negedge clk);
        sif.smp_valid = 1'b0;
        clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int op; int a; int b; int res; int cout; int err;
    } vec_t;

    vec_t tab[6];

    initial begin
        int a, b, op, r, c;

        tab[0] = '{0, 5, 3, 8, 0, 0};
        tab[1] = '{1, 7, 4, 3, 0, 0};
        tab[2] = '{2, 12, 10, 8, 0, 0};
        tab[3] = '{3, 5, 10, 15, 0, 0};
        tab[4] = '{1, 3, 5, 14, 1, 0};
        tab[5] = '{0, 15, 15, 15, 0, 1};

        sif.smp_valid = 0; sif.smp_a = 0; sif.smp_b = 0;
        sif.smp_op = 0; sif.smp_res = 0; sif.smp_cout = 0;
        model_clear();

        // reset / idle
        repeat (2) begin
            @(negedge clk);
            compare_all();
        end
        rst_n = 1'b1;
        idle(2);

        // clean back-to-back stream, then the single trojan hit
        for (int i = 0; i < 5; i++)
            step(1, tab[i].a, tab[i].b, tab[i].op, tab[i].res, tab[i].cout, 0, tab[i].err);
        idle(2);
        check("clean_checked", 0, ccnt[0], 5);
        check("clean_err", 0, ecnt[0], 0);
        check("clean_alarm", 0, al[0], 0);

        step(1, tab[5].a, tab[5].b, tab[5].op, tab[5].res, tab[5].cout, 0, tab[5].err);
        idle(2);
        check("hit_err_cnt", 0, ecnt[0], 1);
        check("hit_alarm", 0, al[0], 1);
        check("hit_cap_a", 0, ca[0], 15);
        check("hit_cap_res", 0, cr[0], 15);
        check("hit_cap_exp_res", 0, cer[0], 14);
        check("hit_cap_exp_cout", 0, cec[0], 1);
        check("hit_thr3_alarm", 1, al[1], 0);

        // threshold 3: alarm rises with the third check, capture holds the first
        step(0, 0, 0, 0, 0, 0, 1, -1);
        step(1, 9, 6, 0, 5, 1, 0, 1);
        step(1, 3, 12, 3, 15, 1, 0, 1);
        check("thr_alarm_1st", 1, al[1], 0);
        step(1, 15, 15, 2, 14, 1, 0, 1);
        check("thr_alarm_2nd", 1, al[1], 0);
        step(0, 0, 0, 0, 0, 0, 0, -1);
        check("thr_alarm_3rd", 1, al[1], 1);
        idle(1);
        check("thr_cap_a", 1, ca[1], 9);
        check("thr_cap_b", 1, cb[1], 6);
        check("thr_cap_exp_res", 1, cer[1], 15);
        check("thr_cap_exp_cout", 1, cec[1], 0);

        // saturation of the 4-bit counters
        step(0, 0, 0, 0, 0, 0, 1, -1);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0, 0, 0, 1);
        idle(2);
        check("sat_err", 2, ecnt[2], 15);
        check("sat_checked", 2, ccnt[2], 15);
        check("sat_alarm", 2, al[2], 1);
        check("sat_err_wide", 0, ecnt[0], 20);

        // clr one cycle after a mismatching sample, then clr together with a sample
        step(0, 0, 0, 0, 0, 0, 1, -1);
        step(1, 2, 2, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, -1);
        idle(3);
        check("clr_mid_checked", 0, ccnt[0], 0);
        check("clr_mid_capv", 0, capv[0], 0);
        step(1, 2, 2, 0, 0, 0, 1, 1);
        idle(3);
        check("clr_same_checked", 0, ccnt[0], 0);

        // async reset with a sample in stage 1, then in stage 2
        step(1, 4, 4, 1, 1, 1, 0, 1);
        async_reset();
        idle(3);
        step(1, 4, 4, 1, 1, 1, 0, 1);
        idle(1);
        async_reset();
        idle(3);
        check("rst_mid_err", 0, ecnt[0], 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 3));
            golden(a, b, op, r, c);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 0) r = r ^ int'($urandom_range(1, 15));
                else c = c ^ 1;
            end
            if ($urandom_range(0, 199) == 0) async_reset();
            step(($urandom_range(0, 3) != 0), a, b, op, r, c,
                 ($urandom_range(0, 49) == 0), -1);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
